// File: rtl/onfi_bus_arbiter_if.sv
// Engine-side request/grant handshake plus the shared ONFI pin set seen by the arbiter.
// master: command engines / pad ring side; slave: the arbiter itself.
interface onfi_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic                    onfi_rb;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      done;
  logic [NUM_REQ-1:0]      eng_cle;
  logic [NUM_REQ-1:0]      eng_ale;
  logic [NUM_REQ-1:0]      eng_wen;
  logic [NUM_REQ-1:0]      eng_dq_en;
  logic [NUM_REQ-1:0]      eng_dqs_en;
  logic [32*NUM_REQ-1:0]   eng_dq_o;

  logic [NUM_REQ-1:0]      gnt;
  logic                    busy;
  logic                    timeout_err;
  logic [ID_W-1:0]         timeout_id;
  logic                    onfi_cen;
  logic                    onfi_cle;
  logic                    onfi_ale;
  logic                    onfi_wen;
  logic                    onfi_dq_en;
  logic                    onfi_dqs_en;
  logic [31:0]             onfi_dq_o;

  modport master (
    output onfi_rb, req, done, eng_cle, eng_ale, eng_wen, eng_dq_en, eng_dqs_en, eng_dq_o,
    input  gnt, busy, timeout_err, timeout_id,
    input  onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_en, onfi_dqs_en, onfi_dq_o
  );

  modport slave (
    input  onfi_rb, req, done, eng_cle, eng_ale, eng_wen, eng_dq_en, eng_dqs_en, eng_dq_o,
    output gnt, busy, timeout_err, timeout_id,
    output onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_en, onfi_dqs_en, onfi_dq_o
  );
endinterface

// File: rtl/onfi_bus_arbiter.sv
// Round-robin owner of the shared ONFI pins: grant 1 cycle after request, CE# setup, pass-through, watchdog.
// Requests wait while R/B# is busy or another engine owns the bus; 2-cycle minimum gap between grants.
module onfi_bus_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int CS_SETUP_CYC = 1
) (
  input  logic               onfi_clk,
  input  logic               onfi_rst_n,
  onfi_bus_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + CS_SETUP_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ID_W-1:0]    owner, owner_nxt;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic               cen_q, cen_nxt;
  logic               terr_q, terr_nxt;
  logic [ID_W-1:0]    tid_q, tid_nxt;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 pick_vld;
  logic [ID_W-1:0]      pick_id;
  logic                 owner_done;

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is then the round-robin winner.
  always_comb begin
    req_dbl  = {bus.req, bus.req} >> rr_ptr;
    req_rot  = req_dbl[NUM_REQ-1:0];
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_vld = 1'b1;
        pick_id  = (int'(rr_ptr) + i >= NUM_REQ) ? ID_W'(int'(rr_ptr) + i - NUM_REQ)
                                                 : ID_W'(int'(rr_ptr) + i);
      end
    end
  end

  assign owner_done = bus.done[owner];

  always_ff @(posedge onfi_clk or negedge onfi_rst_n) begin
    if (!onfi_rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      gnt_q  <= '0;
      cen_q  <= 1'b1;
      terr_q <= 1'b0;
      tid_q  <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      gnt_q  <= gnt_nxt;
      cen_q  <= cen_nxt;
      terr_q <= terr_nxt;
      tid_q  <= tid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      S_IDLE: begin
        if (bus.onfi_rb && pick_vld) begin
          owner_nxt = pick_id;
          cnt_nxt   = '0;
          state_nxt = (CS_SETUP_CYC == 0) ? S_GRANT : S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CNT_W'(CS_SETUP_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_GRANT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GRANT: begin
        // A done arriving on the watchdog's last cycle still wins: normal release.
        if (owner_done || cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = S_RELEASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        rr_ptr_nxt = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt  = '0;
    cen_nxt  = 1'b1;
    terr_nxt = 1'b0;
    tid_nxt  = tid_q;
    if (state_nxt == S_SETUP || state_nxt == S_GRANT) begin
      gnt_nxt = NUM_REQ'(1) << owner_nxt;
      cen_nxt = 1'b0;
    end
    if (state == S_GRANT && state_nxt == S_RELEASE && !owner_done) begin
      terr_nxt = 1'b1;
      tid_nxt  = owner;
    end

    bus.onfi_cle    = 1'b0;
    bus.onfi_ale    = 1'b0;
    bus.onfi_wen    = 1'b1;
    bus.onfi_dq_en  = 1'b0;
    bus.onfi_dqs_en = 1'b0;
    bus.onfi_dq_o   = '0;
    if (state == S_GRANT) begin
      bus.onfi_cle    = bus.eng_cle[owner];
      bus.onfi_ale    = bus.eng_ale[owner];
      bus.onfi_wen    = bus.eng_wen[owner];
      bus.onfi_dq_en  = bus.eng_dq_en[owner];
      bus.onfi_dqs_en = bus.eng_dqs_en[owner];
      bus.onfi_dq_o   = bus.eng_dq_o[{owner, 5'd0} +: 32];
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.onfi_cen    = cen_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.timeout_err = terr_q;
  assign bus.timeout_id  = tid_q;

endmodule

// File: doc/onfi_bus_arbiter.md
Name: onfi_bus_arbiter

Overview:
- Shares one ONFI pin set (CE#, CLE, ALE, WE#, DQ output and enable, DQS enable) between NUM_REQ command engines, such as the get/set-feature and page read/program sequencers.
- Grants the bus round-robin, frames each engine's transaction with CE#, waits for R/B# ready, and forces release on a hung engine through a watchdog.
- Sits between the command engines and the ONFI pad ring.

Parameters:
NUM_REQ, 4, number of requesting engines (2..8)
ID_W, 2, width of requester index; must equal clog2(NUM_REQ)
TIMEOUT_CYC, 1024, max onfi_clk cycles an owner may hold the bus
CS_SETUP_CYC, 1, cycles CE# is low before the owner's signals are passed through

Ports:
onfi_clk  in  1  ONFI interface clock; all state updates on posedge
onfi_rst_n  in  1  asynchronous active-low reset
onfi_rb  in  1  NAND R/B#; 1 = ready
req  in  NUM_REQ  per-engine bus request; level, held until grant
done  in  NUM_REQ  per-engine single-cycle end-of-transaction pulse
eng_cle  in  NUM_REQ  per-engine CLE
eng_ale  in  NUM_REQ  per-engine ALE
eng_wen  in  NUM_REQ  per-engine WE#
eng_dq_en  in  NUM_REQ  per-engine DQ output enable
eng_dqs_en  in  NUM_REQ  per-engine DQS output enable
eng_dq_o  in  32*NUM_REQ  per-engine DQ data; engine i uses bits [32i+31:32i]
gnt  out  NUM_REQ  one-hot grant; all zero when no owner
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse when the watchdog forces release
timeout_id  out  ID_W  index of the timed-out owner; holds until the next timeout
onfi_cen  out  1  CE# to NAND
onfi_cle  out  1  muxed CLE
onfi_ale  out  1  muxed ALE
onfi_wen  out  1  muxed WE#
onfi_dq_en  out  1  muxed DQ output enable
onfi_dqs_en  out  1  muxed DQS output enable
onfi_dq_o  out  32  muxed DQ data

Behaviour:
- Reset (async, onfi_rst_n=0):
  - state=IDLE, gnt=0, busy=0, timeout_err=0, timeout_id=0, rr_ptr=0.
  - onfi_cen=1, onfi_cle=0, onfi_ale=0, onfi_wen=1, onfi_dq_en=0, onfi_dqs_en=0, onfi_dq_o=0.
  - Applies immediately, including mid-transaction.
- Pin mux:
  - Combinational from owner's eng_* only while state=GRANT.
  - In all other states pins take the idle values above, except onfi_cen.
- onfi_cen (registered):
  - 0 in SETUP and GRANT.
  - 1 in IDLE and RELEASE.
- FSM:
  - IDLE: if onfi_rb=1 and req!=0, select the first set req bit searching upward from rr_ptr with wrap. Latch owner, set gnt[owner], clear the cycle counter, go to SETUP. If onfi_rb=0, stay in IDLE; requests wait.
  - SETUP: hold for CS_SETUP_CYC cycles with CE# low, then go to GRANT. gnt is already high, so the engine may start on its next negedge.
  - GRANT: increment the counter each cycle.
    - done[owner]=1: go to RELEASE.
    - Otherwise, counter reaches TIMEOUT_CYC-1: go to RELEASE, pulse timeout_err, timeout_id=owner.
    - done on the same cycle as the timeout has priority: normal release, no error.
  - RELEASE: one cycle with gnt=0 and CE# high (tCH). rr_ptr=(owner+1) mod NUM_REQ. Go to IDLE.
- Minimum gap between back-to-back grants: 2 cycles (RELEASE, then IDLE evaluation).
- Rule violations, ignored:
  - done from a non-owner.
  - req deasserted by the owner during GRANT; the grant is held until done or timeout.
  - req deasserted before being granted simply drops out of arbitration.
- Simultaneous requests: strictly round-robin from rr_ptr, so no engine waits more than NUM_REQ-1 grants.
- The 32-bit data path passes through unmodified.

Test Plan:
- Reset: assert onfi_rst_n=0 mid-GRANT -> same cycle onfi_cen=1, gnt=0, onfi_wen=1, onfi_dq_en=0; after release state=IDLE, rr_ptr=0.
- Single request: req=4'b0010, onfi_rb=1 -> gnt=0010 next cycle, onfi_cen=0. Pins follow engine 1 from cycle 3 (eng_dq_o[63:32]=32'hEE appears on onfi_dq_o). done[1] pulse -> gnt=0 and onfi_cen=1 the following cycle.
- Round-robin: req=4'b1111 held, each owner sends done after 5 cycles -> grant order 0,1,2,3,0.
- R/B# stall: onfi_rb=0 with req=4'b0001 for 20 cycles -> gnt stays 0, busy=0. onfi_rb rises -> gnt=0001 on the next cycle.
- Watchdog: TIMEOUT_CYC=16, engine 2 granted and never sends done -> after 16 GRANT cycles timeout_err pulses for one cycle, timeout_id=2, bus released, then engine 3 is granted if requesting.
- Stray done: during engine 0 ownership pulse done[3], then drop req[0] -> grant is held until done[0].
